// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first adder that reuses one full adder for WIDTH cycles.
// Optional subtract mode (adds the Sub port) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [CW-1:0]    cnt;
  logic             cy;

  // Operand B and the carry seed as loaded on Start acceptance.
  logic [WIDTH-1:0] b_load;
  logic             cy_load;

`ifdef SERIAL_ADDER_SUB_EN
  // A - B is computed as A + ~B + 1, so the carry out doubles as "no borrow".
  assign b_load  = Sub ? ~B : B;
  assign cy_load = Sub;
`else
  assign b_load  = B;
  assign cy_load = 1'b0;
`endif

  // Full adder built from two half adders and an OR gate.
  logic ha0_s, ha0_c, ha1_c;
  logic fa_s, fa_c;

  assign ha0_s = a_sr[0] ^ b_sr[0];
  assign ha0_c = a_sr[0] & b_sr[0];
  assign fa_s  = ha0_s ^ cy;
  assign ha1_c = ha0_s & cy;
  assign fa_c  = ha0_c | ha1_c;

  // NOTE: every flop here, datapath included, is cleared by reset so an abandoned
  // operation leaves no residue; all sequential updates use non-blocking assignment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      Sum   <= '0;
      Carry <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      // Status flags are registered copies of the current state.
      Busy <= (state == RUN);
      Done <= (state == DONE);

      case (state)
        IDLE: begin
          if (Start) begin
            a_sr  <= A;
            b_sr  <= b_load;
            psum  <= '0;
            cnt   <= '0;
            cy    <= cy_load;
            state <= RUN;
          end
        end

        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          psum <= {fa_s, psum[WIDTH-1:1]};
          cy   <= fa_c;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            Sum   <= {fa_s, psum[WIDTH-1:1]};
            Carry <= fa_c;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against an arithmetic model.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract mode.
module tb_serial_adder;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
  logic         Sub;
`endif
  logic [W-1:0] Sum;
  logic         Carry;
  logic         Busy;
  logic         Done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  serial_adder #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub   (Sub),
`endif
    .A     (A),
    .B     (B),
    .Sum   (Sum),
    .Carry (Carry),
    .Busy  (Busy),
    .Done  (Done)
  );

  // Reference: {carry, sum} from plain arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    logic [W-1:0] diff;
    if (sub) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request; returns #1 after the accepting edge with Start dropped.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    Start = 1'b1;
    A     = a;
    B     = b;
`ifdef SERIAL_ADDER_SUB_EN
    Sub   = sub;
`else
    if (sub) check("sub_unsupported", 32'(sub), 32'd0);
`endif
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Follow an accepted operation to its Done pulse and check result and timing.
  task automatic finish_op(input string tag, input logic [W:0] exp, input int glitch_at,
                           input bit chk_hold, input logic [W-1:0] prev, input bit chk_tail);
    int edges    = 0;
    int busy_cnt = 0;
    bit seen     = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(posedge Clk);
      #1;
      edges++;
      if (Busy) busy_cnt++;
      if (glitch_at != 0 && edges == glitch_at) begin
        Start = 1'b1;
        A     = '1;
        B     = '1;
      end
      if (glitch_at != 0 && edges == glitch_at + 1) Start = 1'b0;
      if (chk_hold && edges < W) check({tag, "_hold"}, 32'(Sum), 32'(prev));
      if (Done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_sum"}, 32'(Sum), 32'(exp[W-1:0]));
    check({tag, "_carry"}, 32'(Carry), 32'(exp[W]));
    if (chk_tail) begin
      @(posedge Clk);
      #1;
      check({tag, "_done_width"}, 32'(Done), 32'd0);
    end
  endtask

  initial begin
    int       extra;
    logic [W-1:0] ra, rb;
    logic     rs;

    Rst_n = 1'b0;
    Start = 1'b0;
    A     = '0;
    B     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    Sub   = 1'b0;
`endif
    repeat (3) @(posedge Clk);
    #1;
    check("reset_sum", 32'(Sum), 32'd0);
    check("reset_carry", 32'(Carry), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);

    // Start is presented on the very first edge after reset release.
    Rst_n = 1'b1;
    launch(8'h0F, 8'h01, 1'b0);
    finish_op("add_0f_01", model(8'h0F, 8'h01, 1'b0), 0, 1'b0, '0, 1'b1);

    // Idle with operand churn must not disturb the result.
    A = 8'h55;
    B = 8'hAA;
    repeat (4) @(posedge Clk);
    #1;
    check("idle_hold_sum", 32'(Sum), 32'h10);
    check("idle_hold_busy", 32'(Busy), 32'd0);

    launch(8'hFF, 8'h01, 1'b0);
    finish_op("add_ff_01", model(8'hFF, 8'h01, 1'b0), 0, 1'b0, '0, 1'b1);
    launch(8'hFF, 8'hFF, 1'b0);
    finish_op("add_ff_ff", model(8'hFF, 8'hFF, 1'b0), 0, 1'b0, '0, 1'b1);

    // Start pulsed with new operands during RUN must be ignored.
    launch(8'h12, 8'h34, 1'b0);
    finish_op("restart_ignored", model(8'h12, 8'h34, 1'b0), 3, 1'b0, '0, 1'b1);
    extra = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge Clk);
      #1;
      if (Done || Busy) extra++;
    end
    check("restart_no_second_op", 32'(extra), 32'd0);
    check("restart_sum_kept", 32'(Sum), 32'h46);

    // Reset mid-RUN abandons the operation.
    launch(8'h80, 8'h80, 1'b0);
    repeat (4) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    check("midreset_sum", 32'(Sum), 32'd0);
    check("midreset_carry", 32'(Carry), 32'd0);
    check("midreset_busy", 32'(Busy), 32'd0);
    check("midreset_done", 32'(Done), 32'd0);
    #1;
    Rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge Clk);
      #1;
      if (Done || Busy) extra++;
    end
    check("midreset_no_done", 32'(extra), 32'd0);
    check("midreset_sum_after", 32'(Sum), 32'd0);
    launch(8'h01, 8'h02, 1'b0);
    finish_op("after_reset_01_02", model(8'h01, 8'h02, 1'b0), 0, 1'b0, '0, 1'b1);

    // Back-to-back with Start held high; the old Sum holds until the new load.
    Start = 1'b1;
    A     = 8'h21;
    B     = 8'h43;
    @(posedge Clk);
    #1;
    finish_op("b2b_first", model(8'h21, 8'h43, 1'b0), 0, 1'b1, 8'h03, 1'b0);
    A = 8'h7F;
    B = 8'h90;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    check("b2b_done_width", 32'(Done), 32'd0);
    finish_op("b2b_second", model(8'h7F, 8'h90, 1'b0), 0, 1'b1, 8'h64, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    launch(8'h05, 8'h03, 1'b1);
    finish_op("sub_05_03", model(8'h05, 8'h03, 1'b1), 0, 1'b0, '0, 1'b1);
    launch(8'h03, 8'h05, 1'b1);
    finish_op("sub_03_05", model(8'h03, 8'h05, 1'b1), 0, 1'b0, '0, 1'b1);
`endif

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      #1;
      launch(ra, rb, rs);
      finish_op($sformatf("rand%0d_%h_%h_%0d", n, ra, rb, rs), model(ra, rb, rs), 0, 1'b0, '0,
                1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits: augend, captured when Start is accepted.
REQ-006 SHALL have port B, input, WIDTH bits: addend, captured when Start is accepted.
REQ-007 SHALL have port Sum, output, WIDTH bits: registered result of the last completed operation.
REQ-008 SHALL have port Carry, output, 1 bit: registered carry-out of the last completed operation.
REQ-009 SHALL have port Busy, output, 1 bit: high while in the RUN state.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle pulse, high while in the DONE state.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with Start=1 at a rising edge, capture A and B into shift registers, clear the bit counter and carry flop, and enter RUN.
REQ-013 SHALL, in IDLE with Start=0, remain in IDLE.
REQ-014 SHALL, on each RUN edge, add the operand LSBs and the carry flop using one full adder built from two half adders plus an OR gate.
REQ-015 SHALL, on each RUN edge, shift the sum bit into the partial-sum register MSB-side (LSB-first arithmetic), shift both operands right by one, and store the new carry.
REQ-016 SHALL leave RUN after exactly WIDTH edges, at which point the counter reaches WIDTH-1 and wraps to 0.
REQ-017 SHALL, on the edge leaving RUN, load Sum with the completed partial sum and Carry with the final carry-out, then enter DONE.
REQ-018 SHALL remain in DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-019 SHALL meet the following latency: Start accepted at edge k gives Done=1 during the cycle after edge k+WIDTH+1, so Done is first high WIDTH+1 edges after acceptance.
REQ-020 SHALL ignore Start while in RUN or DONE; no restart, no operand recapture, and no effect on the operation in progress.
REQ-021 SHALL hold Sum and Carry stable from one result load until the next result load; operand changes and an idle Start=0 SHALL not alter them.
REQ-022 SHALL generate Busy and Done purely from FSM state, glitch-free and registered.
REQ-023 SHALL produce Sum equal to (A+B) mod 2^WIDTH and Carry equal to bit WIDTH of A+B.

Reset
REQ-024 SHALL, while Rst_n=0, force: state=IDLE, Sum=0, Carry=0, Busy=0, Done=0, counter=0, carry flop=0, operand and partial-sum registers=0.
REQ-025 SHALL, on a reset asserted mid-RUN, abandon the operation; no Done pulse follows and Sum/Carry read 0.
REQ-026 SHALL treat the first rising edge with Rst_n=1 as an ordinary IDLE edge, so Start can be accepted on it.

Configuration
REQ-027 SHALL, when macro SERIAL_ADDER_SUB_EN is defined, add input port Sub (1 bit), captured with A and B at Start acceptance.
REQ-028 SHALL, with SERIAL_ADDER_SUB_EN defined and Sub=1, initialise the carry flop to 1 and use the bitwise inverse of B, giving Sum=(A-B) mod 2^WIDTH and Carry=1 when A>=B (no borrow), else 0.
REQ-029 SHALL, with SERIAL_ADDER_SUB_EN defined and Sub=0, behave as in REQ-012 to REQ-023.
REQ-030 SHALL, when SERIAL_ADDER_SUB_EN is undefined, have no Sub port, addition only, and no subtraction logic present.

Verification (WIDTH=8)
REQ-031 SHALL cover: reset, then Start with A=0x0F, B=0x01 -> Busy high 8 cycles, Done pulses 9 edges after acceptance, Sum=0x10, Carry=0.
REQ-032 SHALL cover: A=0xFF, B=0x01 -> Sum=0x00, Carry=1; A=0xFF, B=0xFF -> Sum=0xFE, Carry=1.
REQ-033 SHALL cover: Start accepted with A=0x12, B=0x34, then Start pulsed with A=0xFF, B=0xFF at RUN cycle 3 -> result Sum=0x46, Carry=0, with exactly one Done pulse.
REQ-034 SHALL cover: Rst_n pulsed low at RUN cycle 4 of 0x80+0x80 -> no Done pulse, Sum=0x00, Carry=0, state IDLE; a subsequent 0x01+0x02 -> Sum=0x03.
REQ-035 SHALL cover: back-to-back Start held high -> a new operation is accepted on the first IDLE edge after DONE, and the previous Sum holds until the new result loads.
REQ-036 SHALL cover, with SERIAL_ADDER_SUB_EN defined: Sub=1, 0x05-0x03 -> Sum=0x02, Carry=1; Sub=1, 0x03-0x05 -> Sum=0xFE, Carry=0.
